// File: rtl/clock_divider_multi.sv
// clock_divider_multi
//   N-channel programmable clock divider. Every channel divides clock_in by its
//   own run-time divisor and produces a ~50% duty divided clock plus a
//   one-cycle tick at the end of each output period. A new divisor written to a
//   running channel is held pending until that channel's next wrap, so the
//   divided clock never glitches. A write to a stopped channel loads at once.
//
// Parameters
//   N_CH        number of independent channels (1..16)
//   CNT_W       counter / divisor width per channel
//   DEFAULT_DIV divisor loaded into every channel at reset (>= 2)
//   CH_W        wr_ch width, 2**CH_W >= N_CH
//
// Ports
//   clock_in   in   1      input clock, all logic on its rising edge
//   reset_n    in   1      asynchronous active-low reset
//   en         in   N_CH   per-channel run enable
//   wr_en      in   1      divisor write strobe (one cycle)
//   wr_ch      in   CH_W   channel index for the write
//   wr_div     in   CNT_W  new divisor value
//   wr_err     out  1      one-cycle pulse: write rejected (div < 2 or bad channel)
//   clock_out  out  N_CH   divided clocks, bit i = channel i
//   tick       out  N_CH   one-cycle pulse per output period, per channel
//   sync_in    in   1      only when CLKDIV_SYNC_EN is defined: forces every
//                          enabled channel back to count 0 (no tick), applying
//                          any pending divisor
//
// Build option
//   CLKDIV_SYNC_EN  adds the sync_in port and the forced-wrap behaviour.

module clock_divider_multi #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 28,
  parameter int DEFAULT_DIV = 10,
  parameter int CH_W        = 2
) (
  input  logic              clock_in,
  input  logic              reset_n,
  input  logic [N_CH-1:0]   en,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [CNT_W-1:0]  wr_div,
  output logic              wr_err,
  output logic [N_CH-1:0]   clock_out,
  output logic [N_CH-1:0]   tick
`ifdef CLKDIV_SYNC_EN
  ,
  input  logic              sync_in
`endif
);

  logic sync_req;
  logic wr_bad;
  logic wr_ok;

`ifdef CLKDIV_SYNC_EN
  assign sync_req = sync_in;
`else
  assign sync_req = 1'b0;
`endif

  always_comb begin
    wr_bad = 1'b0;
    if (wr_div < CNT_W'(2))
      wr_bad = 1'b1;
    if (32'(wr_ch) >= 32'(N_CH))
      wr_bad = 1'b1;
    wr_ok = wr_en && !wr_bad;
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n)
      wr_err <= 1'b0;
    else
      wr_err <= wr_en && wr_bad;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] div_pend;
    logic             pend_vld;
    logic             co_q;
    logic             tick_q;
    logic             hit;
    logic             wrap;
    logic [CNT_W-1:0] last;

    always_comb begin
      hit  = wr_ok && (32'(wr_ch) == 32'(g));
      last = div_act - CNT_W'(1);
      // >= rather than == so an out-of-range count recovers on its own.
      wrap = cnt >= last;
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
        cnt      <= '0;
        div_act  <= CNT_W'(DEFAULT_DIV);
        div_pend <= '0;
        pend_vld <= 1'b0;
        co_q     <= 1'b0;
        tick_q   <= 1'b0;
      end else if (!en[g]) begin
        cnt    <= '0;
        co_q   <= 1'b0;
        tick_q <= 1'b0;
        if (hit) begin
          div_act  <= wr_div;
          pend_vld <= 1'b0;
        end
      end else begin
        if (sync_req) begin
          cnt    <= '0;
          co_q   <= 1'b0;
          tick_q <= 1'b0;
        end else begin
          cnt    <= wrap ? '0 : cnt + CNT_W'(1);
          co_q   <= cnt < (div_act >> 1);
          tick_q <= cnt == last;
        end
        if ((wrap || sync_req) && pend_vld) begin
          div_act  <= div_pend;
          pend_vld <= 1'b0;
        end
        // Placed after the wrap update: a write landing on the wrap cycle
        // becomes pending for the following wrap instead of being consumed.
        if (hit) begin
          div_pend <= wr_div;
          pend_vld <= 1'b1;
        end
      end
    end

    assign clock_out[g] = co_q;
    assign tick[g]      = tick_q;
  end

endmodule
